carry_save_resolver: RTL and testbench

Sequential carry-propagate stage that turns the redundant three-row output of the 6:3 column compressors back into a single binary value. It consumes vectors S (weight 1), C (weight 2) and C1 (weight 4) and produces S + 2·C + 4·C1. It resolves SEG bits per cycle with a registered inter-segment carry. It sits at the tail of the compressor tree, ahead of any logic that needs a plain binary operand.

---
 rtl/carry_save_pkg.sv | 16 +
 rtl/segment_adder_3.sv | 21 ++
 rtl/carry_save_resolver.sv | 100 ++++++++++
 tb/tb_carry_save_resolver.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/carry_save_pkg.sv
// Shared types and sizing helpers for the carry-save resolver.
package carry_save_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned CARRY_W = 2;

  function automatic int unsigned nseg(input int unsigned width, input int unsigned seg);
    return (width + 3 + seg - 1) / seg;
  endfunction

endpackage

// File: rtl/segment_adder_3.sv
// Three-operand SEG-bit adder with a 2-bit carry in/out; combinational.
module segment_adder_3
  import carry_save_pkg::*;
#(
  parameter int unsigned SEG = 64
) (
  input  logic [SEG-1:0]     a,
  input  logic [SEG-1:0]     b,
  input  logic [SEG-1:0]     d,
  input  logic [CARRY_W-1:0] cin,
  output logic [SEG-1:0]     sum,
  output logic [CARRY_W-1:0] cout
);

  logic [SEG+CARRY_W-1:0] total;

  assign total = {{CARRY_W{1'b0}}, a} + {{CARRY_W{1'b0}}, b} + {{CARRY_W{1'b0}}, d}
               + {{SEG{1'b0}}, cin};
  assign {cout, sum} = total;

endmodule

// File: rtl/carry_save_resolver.sv
// Resolves S + 2*C + 4*C1 into plain binary, SEG bits per cycle with a
// registered 2-bit inter-segment carry.
module carry_save_resolver
  import carry_save_pkg::*;
#(
  parameter int unsigned WIDTH = 1024,
  parameter int unsigned SEG   = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] c1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+2:0] result
);

  localparam int unsigned RW   = WIDTH + 3;
  localparam int unsigned NSEG = nseg(WIDTH, SEG);
  localparam int unsigned EXT  = NSEG * SEG;
  localparam int unsigned KW   = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSEG - 1);

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q;
  logic [EXT-1:0]      a_q, b_q, d_q;
  logic [CARRY_W-1:0]  carry_q;
  logic [RW-1:0]       result_q;
  logic [SEG-1:0]      seg_sum;
  logic [CARRY_W-1:0]  seg_cout;
  logic [RW-1:0]       slice_mask, slice_data;
  logic                accept;

  // Operands shift down each cycle, so only slice 0 ever reaches the adder.
  segment_adder_3 #(.SEG(SEG)) u_add (
    .a    (a_q[SEG-1:0]),
    .b    (b_q[SEG-1:0]),
    .d    (d_q[SEG-1:0]),
    .cin  (carry_q),
    .sum  (seg_sum),
    .cout (seg_cout)
  );

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign accept    = in_valid && in_ready;

  // Slice k written in place; bits above RW in the top segment drop off.
  assign slice_mask = RW'({SEG{1'b1}}) << (32'(k_q) * SEG);
  assign slice_data = RW'(seg_sum) << (32'(k_q) * SEG);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (k_q == K_LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      carry_q  <= '0;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= EXT'(s);
            b_q     <= EXT'({c, 1'b0});
            d_q     <= EXT'({c1, 2'b00});
            carry_q <= '0;
            k_q     <= '0;
          end
        end
        RUN: begin
          result_q <= (result_q & ~slice_mask) | slice_data;
          carry_q  <= seg_cout;
          a_q      <= a_q >> SEG;
          b_q      <= b_q >> SEG;
          d_q      <= d_q >> SEG;
          if (k_q != K_LAST) k_q <= k_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_carry_save_resolver.sv
// Directed and randomized checks of carry_save_resolver at WIDTH=16, SEG=8.
module tb_carry_save_resolver;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SEG   = 8;
  localparam int unsigned RW    = WIDTH + 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] s, c, c1;
  logic             out_valid;
  logic             out_ready;
  logic [RW-1:0]    result;

  int checks   = 0;
  int failures = 0;
  logic [RW-1:0] exp_q[$];

  carry_save_resolver #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .c         (c),
    .c1        (c1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] sv, cv, c1v);
    return RW'(sv) + RW'(cv) * 2 + RW'(c1v) * 4;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic accept(input logic [WIDTH-1:0] sv, cv, c1v);
    bit done = 0;
    s = sv; c = cv; c1 = c1v; in_valid = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      if (in_ready) done = 1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) check("accept_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic wait_result(input string tag, input logic [RW-1:0] exp);
    bit seen = 0;
    for (int t = 0; t < 100 && !seen; t++) begin
      if (out_valid) seen = 1;
      else @(negedge clk);
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check(tag, 64'(result), 64'(exp));
    check({tag, "_final_carry"}, 64'(dut.carry_q), 64'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] rs, rc, rc1;
    logic [RW-1:0]    held;
    int               handshakes;
    bit               got;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    s = '0; c = '0; c1 = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Latency: accept on E0, out_valid first high after E3.
    out_ready = 1'b1;
    accept(16'h0001, 16'h0001, 16'h0001);
    check("lat_e0_in_ready", 64'(in_ready), 64'd0);
    check("lat_e0_out_valid", 64'(out_valid), 64'd0);
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      check($sformatf("lat_e%0d_out_valid", n), 64'(out_valid), 64'(n == 3));
      check($sformatf("lat_e%0d_in_ready", n), 64'(in_ready), 64'd0);
    end
    check("lat_result", 64'(result), 64'h00007);
    @(negedge clk);
    check("lat_e4_out_valid", 64'(out_valid), 64'd0);
    check("lat_e4_in_ready", 64'(in_ready), 64'd1);

    accept(16'hFFFF, 16'hFFFF, 16'hFFFF);
    wait_result("all_ones", 19'h6FFF9);
    @(negedge clk);

    accept(16'h00FF, 16'h0080, 16'h0040);
    wait_result("seg_cross", 19'h002FF);
    @(negedge clk);

    // Backpressure: DONE holds result and refuses new input.
    out_ready = 1'b0;
    accept(16'hABCD, 16'h1234, 16'h0F0F);
    held = model(16'hABCD, 16'h1234, 16'h0F0F);
    wait_result("bp_first", held);
    for (int i = 0; i < 5; i++) begin
      s = 16'h5555; c = 16'h0AAA; c1 = 16'h0123; in_valid = 1'b1;
      @(negedge clk);
      check("bp_hold_result", 64'(result), 64'(held));
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_no_accept", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_accepted", 64'(in_ready), 64'd0);
    wait_result("bp_next", model(16'h5555, 16'h0AAA, 16'h0123));
    @(negedge clk);

    // Reset mid-RUN discards the operation.
    accept(16'hFFFF, 16'hFFFF, 16'hFFFF);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_idle", 64'(in_ready), 64'd1);
    accept(16'h1234, 16'h0000, 16'h0000);
    wait_result("midrst_after", 19'h01234);
    @(negedge clk);

    // Randomized traffic with random out_ready.
    handshakes = 0;
    for (int v = 0; v < 1000; v++) begin
      rs = 16'($urandom); rc = 16'($urandom); rc1 = 16'($urandom);
      accept(rs, rc, rc1);
      exp_q.push_back(model(rs, rc, rc1));
      got = 0;
      for (int t = 0; t < 200 && !got; t++) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          got = 1;
          handshakes++;
          if (exp_q.size() == 0) check("rand_duplicate", 64'(result), 64'd0);
          else check("rand_result", 64'(result), 64'(exp_q.pop_front()));
        end
        @(negedge clk);
      end
      if (!got) check("rand_timeout", 64'(out_valid), 64'd1);
      else check("rand_no_dup", 64'(out_valid), 64'd0);
    end
    check("rand_handshakes", 64'(handshakes), 64'd1000);
    check("rand_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
